// File: rtl/pulse_width_meter.sv
// Pulse high-time meter: counts clk samples with pulse==1 and reports over valid/ready.
// Optional WIDTH_OVF_EN adds meas_ovf, flagging a saturated measurement.
module pulse_width_meter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pulse,
    output logic [WIDTH-1:0] meas_width,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic             busy
`ifdef WIDTH_OVF_EN
    ,
    output logic             meas_ovf
`endif
);

    localparam logic [WIDTH-1:0] MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        HOLD
    } state_t;

    state_t           state_q, state_d;
    logic             pulse_q;
    logic             rise;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] width_d;
    logic             valid_d;

    // pulse_q resets high so a pulse already asserted at release is ignored
    assign rise = pulse && !pulse_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pulse_q    <= 1'b1;
            count_q    <= '0;
            meas_width <= '0;
            meas_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            pulse_q    <= pulse;
            count_q    <= count_d;
            meas_width <= width_d;
            meas_valid <= valid_d;
            busy       <= (state_d == COUNT);
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        width_d = meas_width;
        valid_d = meas_valid;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = COUNT;
                    count_d = WIDTH'(1);
                end
            end
            COUNT: begin
                if (pulse) begin
                    if (count_q != MAX) count_d = count_q + 1'b1;
                end else begin
                    width_d = count_q;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (meas_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef WIDTH_OVF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meas_ovf <= 1'b0;
        end else if (state_q == COUNT && !pulse) begin
            meas_ovf <= (count_q == MAX);
        end else if (state_q == HOLD && meas_ready) begin
            meas_ovf <= 1'b0;
        end
    end
`endif

endmodule
